// File: rtl/usb_tx_serializer.sv
// USB transmit bit engine: byte buffer, SYNC, bit stuffing, NRZI and EOP onto D+/D-.
// Optional macro USB_TX_AUTO_SYNC_EN: hardware prepends SYNC_BYTE; otherwise the caller sends SYNC as byte 0.
module usb_tx_serializer #(
   parameter logic [7:0]  SYNC_BYTE   = 8'h80,
   parameter int unsigned STUFF_LIMIT = 6
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       shift_enable,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       d_plus,
   output logic       d_minus,
   output logic       tx_active,
   output logic       tx_err
);
   localparam int unsigned OW = $clog2(STUFF_LIMIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_EOP1,
      S_EOP2,
      S_EOPJ
`ifdef USB_TX_AUTO_SYNC_EN
      , S_SYNC
`endif
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    buf_q, buf_d;
   logic          buf_last_q, buf_last_d;
   logic          buf_full_q, buf_full_d;
   logic [6:0]    sr_q, sr_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic          cur_last_q, cur_last_d;
   logic [OW-1:0] ones_q, ones_d, ones_base;
   logic          level_q, level_d;
   logic          d_plus_q, d_plus_d;
   logic          d_minus_q, d_minus_d;
   logic          tx_active_q, tx_active_d;
   logic          tx_err_q, tx_err_d;
   logic          tx_ready_q, tx_ready_d;
   logic          load, send, bit_val, accept;

   // Next-state: one line slot per shift_enable; send marks a data/SYNC/stuff bit going out
   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      buf_last_d  = buf_last_q;
      buf_full_d  = buf_full_q;
      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      cur_last_d  = cur_last_q;
      ones_d      = ones_q;
      level_d     = level_q;
      d_plus_d    = d_plus_q;
      d_minus_d   = d_minus_q;
      tx_err_d    = 1'b0;
      load        = 1'b0;
      send        = 1'b0;
      bit_val     = 1'b0;
      accept      = tx_valid && tx_ready_q;
      ones_base   = (state_q == S_IDLE) ? '0 : ones_q;

      if (shift_enable) begin
         case (state_q)
            S_IDLE: begin
               if (buf_full_q) begin
`ifdef USB_TX_AUTO_SYNC_EN
                  state_d   = S_SYNC;
                  bit_cnt_d = 3'd0;
                  send      = 1'b1;
                  bit_val   = SYNC_BYTE[0];
`else
                  state_d   = S_DATA;
                  load      = 1'b1;
`endif
               end
            end
`ifdef USB_TX_AUTO_SYNC_EN
            S_SYNC: begin
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_DATA;
                  load    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  send      = 1'b1;
                  bit_val   = SYNC_BYTE[bit_cnt_d];
               end
            end
`endif
            S_DATA: begin
               if (ones_q == OW'(STUFF_LIMIT)) begin
                  send    = 1'b1;
                  bit_val = 1'b0;
               end else if (bit_cnt_q != 3'd7) begin
                  send      = 1'b1;
                  bit_val   = sr_q[0];
                  sr_d      = {1'b0, sr_q[6:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end else if (cur_last_q) begin
                  state_d = S_EOP1;
               end else if (buf_full_q) begin
                  load = 1'b1;
               end else begin
                  state_d  = S_EOP1;
                  tx_err_d = 1'b1;
               end
            end
            S_EOP1:  state_d = S_EOP2;
            S_EOP2:  state_d = S_EOPJ;
            S_EOPJ:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase

         if (load) begin
            send       = 1'b1;
            bit_val    = buf_q[0];
            sr_d       = buf_q[7:1];
            bit_cnt_d  = 3'd0;
            cur_last_d = buf_last_q;
            buf_full_d = 1'b0;
         end

         // NRZI: a 0 toggles, a 1 holds; outside bit slots the line rests on J or SE0
         if (send) begin
            level_d   = bit_val ? level_q : ~level_q;
            ones_d    = bit_val ? ((ones_base == OW'(STUFF_LIMIT)) ? ones_base : ones_base + OW'(1)) : '0;
            d_plus_d  = level_d;
            d_minus_d = ~level_d;
         end else begin
            level_d   = 1'b1;
            ones_d    = '0;
            d_plus_d  = !(state_d == S_EOP1 || state_d == S_EOP2);
            d_minus_d = 1'b0;
         end
      end

      if (accept) begin
         buf_d      = tx_data;
         buf_last_d = tx_last;
         buf_full_d = 1'b1;
      end

      tx_ready_d  = !buf_full_d && !(state_d == S_EOP1 || state_d == S_EOP2 || state_d == S_EOPJ);
      tx_active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         buf_q       <= '0;
         buf_last_q  <= 1'b0;
         buf_full_q  <= 1'b0;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         cur_last_q  <= 1'b0;
         ones_q      <= '0;
         level_q     <= 1'b1;
         d_plus_q    <= 1'b1;
         d_minus_q   <= 1'b0;
         tx_active_q <= 1'b0;
         tx_err_q    <= 1'b0;
         tx_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         buf_last_q  <= buf_last_d;
         buf_full_q  <= buf_full_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         cur_last_q  <= cur_last_d;
         ones_q      <= ones_d;
         level_q     <= level_d;
         d_plus_q    <= d_plus_d;
         d_minus_q   <= d_minus_d;
         tx_active_q <= tx_active_d;
         tx_err_q    <= tx_err_d;
         tx_ready_q  <= tx_ready_d;
      end
   end

   assign d_plus    = d_plus_q;
   assign d_minus   = d_minus_q;
   assign tx_active = tx_active_q;
   assign tx_err    = tx_err_q;
   assign tx_ready  = tx_ready_q;
endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer: fixed and randomized packets against a bit-level line model.
module tb_usb_tx_serializer;
   localparam logic [1:0] LJ  = 2'b10;
   localparam logic [1:0] LK  = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       shift_enable = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready, d_plus, d_minus, tx_active, tx_err;

   int checks = 0;
   int errors = 0;
   int err_total = 0;

   logic [1:0] cap_sym[$];
   logic       cap_err[$];
   logic       cap_rdy[$];

   usb_tx_serializer dut (
      .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_ready(tx_ready), .d_plus(d_plus), .d_minus(d_minus),
      .tx_active(tx_active), .tx_err(tx_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (tx_err === 1'b1) err_total++;
   end

   // Reference: SYNC (0x80) + payload bits LSB-first, stuff a 0 after six 1s, NRZI from J, then SE0 SE0 J
   task automatic model_line(input logic [7:0] payload[$], output logic [1:0] exp[$]);
      logic [7:0] all[$];
      bit bits[$];
      int ones;
      bit lvl;
      all = payload;
      all.push_front(8'h80);
      ones = 0;
      foreach (all[i]) begin
         for (int b = 0; b < 8; b++) begin
            bits.push_back(all[i][b]);
            if (all[i][b]) begin
               ones++;
               if (ones == 6) begin
                  bits.push_back(1'b0);
                  ones = 0;
               end
            end else ones = 0;
         end
      end
      lvl = 1'b1;
      exp.delete();
      foreach (bits[i]) begin
         if (!bits[i]) lvl = !lvl;
         exp.push_back(lvl ? LJ : LK);
      end
      exp.push_back(SE0);
      exp.push_back(SE0);
      exp.push_back(LJ);
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      shift_enable = 1'b0;
      tx_valid = 1'b0;
      tx_last = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic feed(input logic [7:0] payload[$], input bit with_last, input bit chk_ready);
      logic [7:0] bytes[$];
      int budget;
      bit rdy;
      bytes = payload;
`ifndef USB_TX_AUTO_SYNC_EN
      bytes.push_front(8'h80);
`endif
      @(negedge clk);
      foreach (bytes[i]) begin
         tx_valid = 1'b1;
         tx_data  = bytes[i];
         tx_last  = with_last && (i == bytes.size() - 1);
         budget   = 0;
         do begin
            rdy = tx_ready;
            @(negedge clk);
            budget++;
         end while (!rdy && budget < 2000);
         if (!rdy) begin
            checks++; errors++;
            $display("FAIL feed_timeout byte %0d never accepted", i);
            break;
         end
         if (chk_ready && i == 0) begin
            checks++;
            if (tx_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_drop tx_ready=%b required 0 after accept", tx_ready);
            end
         end
      end
      tx_valid = 1'b0;
      tx_last  = 1'b0;
   endtask

   // Strobe with random gaps, capture every active slot; optionally reset after abort_after active slots
   task automatic strobe_capture(input int abort_after);
      bit seen;
      bit done;
      seen = 0;
      done = 0;
      cap_sym.delete(); cap_err.delete(); cap_rdy.delete();
      for (int i = 0; i < 400 && !done; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         shift_enable = 1'b1;
         @(posedge clk);
         #1;
         if (tx_active) begin
            seen = 1;
            cap_sym.push_back({d_plus, d_minus});
            cap_err.push_back(tx_err);
            cap_rdy.push_back(tx_ready);
         end else if (seen) begin
            done = 1;
            checks++;
            if ({d_plus, d_minus} !== LJ) begin
               errors++;
               $display("FAIL idle_after_eop line=%b required %b", {d_plus, d_minus}, LJ);
            end
         end
         @(negedge clk);
         shift_enable = 1'b0;
         if (abort_after > 0 && cap_sym.size() == abort_after) begin
            n_rst = 1'b0;
            #1;
            checks++;
            if ({d_plus, d_minus, tx_active, tx_ready, tx_err} !== 5'b10010) begin
               errors++;
               $display("FAIL async_reset dp,dm,act,rdy,err=%b required 10010",
                        {d_plus, d_minus, tx_active, tx_ready, tx_err});
            end
            @(posedge clk);
            #1;
            checks++;
            if ({d_plus, d_minus, tx_active, tx_ready} !== 4'b1001) begin
               errors++;
               $display("FAIL reset_next_clk dp,dm,act,rdy=%b required 1001",
                        {d_plus, d_minus, tx_active, tx_ready});
            end
            @(negedge clk);
            n_rst = 1'b1;
            done = 1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL strobe_timeout packet did not complete");
      end
   endtask

   task automatic run_packet(input string name, input logic [7:0] payload[$], input bit with_last,
                             input logic [1:0] exp[$], input bit chk_ready);
      int err0, diff, n;
      err0 = err_total;
      fork
         feed(payload, with_last, chk_ready);
         strobe_capture(0);
      join
      diff = -1;
      n = (cap_sym.size() < exp.size()) ? cap_sym.size() : exp.size();
      for (int i = n - 1; i >= 0; i--) if (cap_sym[i] !== exp[i]) diff = i;
      checks++;
      if (cap_sym.size() != exp.size() || diff >= 0) begin
         errors++;
         $display("FAIL %s line: slots %0d required %0d, first diff @%0d got %b required %b", name,
                  cap_sym.size(), exp.size(), diff, (diff >= 0) ? cap_sym[diff] : 2'bxx,
                  (diff >= 0) ? exp[diff] : 2'bxx);
      end
      checks++;
      if (err_total - err0 != (with_last ? 0 : 1)) begin
         errors++;
         $display("FAIL %s tx_err_clocks got %0d required %0d", name, err_total - err0, with_last ? 0 : 1);
      end
      if (!with_last && cap_err.size() >= 3) begin
         checks++;
         if (cap_err[cap_err.size() - 3] !== 1'b1) begin
            errors++;
            $display("FAIL %s tx_err_at_eop1 got %b required 1", name, cap_err[cap_err.size() - 3]);
         end
      end
      if (cap_rdy.size() >= 3) begin
         checks++;
         if ({cap_rdy[cap_rdy.size() - 3], cap_rdy[cap_rdy.size() - 2], cap_rdy[cap_rdy.size() - 1]} !== 3'b000) begin
            errors++;
            $display("FAIL %s ready_in_eop got %b%b%b required 000", name, cap_rdy[cap_rdy.size() - 3],
                     cap_rdy[cap_rdy.size() - 2], cap_rdy[cap_rdy.size() - 1]);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({d_plus, d_minus, tx_active, tx_ready, tx_err} !== 5'b10010) begin
         errors++;
         $display("FAIL reset_values dp,dm,act,rdy,err=%b required 10010",
                  {d_plus, d_minus, tx_active, tx_ready, tx_err});
      end
   endtask

   task automatic test_single_a5();
      logic [7:0] p[$];
      logic [1:0] e[$];
      p = '{8'hA5};
      e = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LK, LJ, LJ, LK, LJ, LJ, LK, LK, SE0, SE0, LJ};
      run_packet("single_a5", p, 1'b1, e, 1'b0);
   endtask

   task automatic test_single_ff();
      logic [7:0] p[$];
      logic [1:0] e[$];
      p = '{8'hFF};
      e = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LK, LK, LK, LK, LK, LJ, LJ, LJ, LJ, SE0, SE0, LJ};
      run_packet("single_ff", p, 1'b1, e, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] p[$];
      logic [1:0] e[$];
      p = '{8'h01, 8'h02};
      model_line(p, e);
      run_packet("back_to_back", p, 1'b1, e, 1'b1);
   endtask

   task automatic test_underrun();
      logic [7:0] p[$];
      logic [1:0] e[$];
      p = '{8'h3C};
      model_line(p, e);
      run_packet("underrun", p, 1'b0, e, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [7:0] p[$];
      logic [1:0] e[$];
      p = '{8'($urandom)};
      fork
         feed(p, 1'b1, 1'b0);
         strobe_capture(11);
      join
      p = '{8'($urandom), 8'hFF};
      model_line(p, e);
      run_packet("after_reset", p, 1'b1, e, 1'b0);
   endtask

   task automatic test_random();
      logic [7:0] p[$];
      logic [1:0] e[$];
      bit lst;
      for (int k = 0; k < 10; k++) begin
         p.delete();
         for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
            case ($urandom_range(0, 3))
               0: p.push_back(8'($urandom));
               1: p.push_back(8'hFF);
               2: p.push_back(8'h7F);
               default: p.push_back(8'hFC);
            endcase
         end
         lst = (k % 4 != 3);
         model_line(p, e);
         run_packet($sformatf("random_%0d", k), p, lst, e, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_single_a5();
      test_single_ff();
      test_back_to_back();
      test_underrun();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
